// File: rtl/incr9_counter.sv
// incr9_counter: programmable 9-bit up-counter fed by a carry-select incrementer.
// Adds load, terminal-count compare, one-shot/continuous FSM, saturate/wrap, sticky ovf.

module incr9 (
    input  logic [8:0] din,
    output logic [8:0] dout,
    output logic       cy
);

    logic [2:0] g0;
    logic [2:0] g1;
    logic [2:0] g2;
    logic       c3;
    logic       c6;

    function automatic logic [2:0] inc3(input logic [2:0] v);
        inc3 = {v[2] ^ (v[1] & v[0]), v[1] ^ v[0], ~v[0]};
    endfunction

    // Each 3-bit group is pre-incremented; group carries pick the result
    always_comb begin
        g0        = inc3(din[2:0]);
        g1        = inc3(din[5:3]);
        g2        = inc3(din[8:6]);
        c3        = &din[2:0];
        c6        = c3 & (&din[5:3]);
        cy        = c6 & (&din[8:6]);
        dout[2:0] = g0;
        dout[5:3] = c3 ? g1 : din[5:3];
        dout[8:6] = c6 ? g2 : din[8:6];
    end

endmodule

module incr9_counter #(
    parameter logic [8:0] RST_VAL = 9'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       en,
    input  logic       load,
    input  logic [8:0] load_val,
    input  logic [8:0] term,
    input  logic       oneshot,
    input  logic       sat,
    input  logic       ovf_clr,
    output logic [8:0] count,
    output logic       busy,
    output logic       done,
    output logic       wrap,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    logic [8:0] inc_out;
    logic       inc_cy;
    logic [8:0] nxt;
    logic       hit;

    incr9 u_incr9 (
        .din  (count),
        .dout (inc_out),
        .cy   (inc_cy)
    );

    // Candidate next count: saturation pins at 1FF, otherwise take the incrementer
    always_comb begin
        nxt = inc_out;
        if (inc_cy && sat) begin
            nxt = 9'h1FF;
        end
        hit = (nxt == term);
    end

    assign busy = (state == RUN);

    // Control FSM with count, pulses and sticky overflow; stop > load > start > en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= RST_VAL;
            done  <= 1'b0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (stop) begin
                state <= IDLE;
                count <= RST_VAL;
            end else if (load) begin
                count <= load_val;
                case (state)
                    DONE: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    IDLE, RUN: begin
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (en) begin
                            count <= nxt;
                            if (inc_cy) begin
                                ovf  <= 1'b1;
                                wrap <= ~sat;
                            end
                            if (hit) begin
                                done <= 1'b1;
                                if (oneshot) begin
                                    state <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_incr9_counter.sv
// tb_incr9_counter: directed plan steps followed by randomized traffic,
// every cycle compared against an arithmetic reference model.

module tb_incr9_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       en;
    logic       load;
    logic [8:0] load_val;
    logic [8:0] term;
    logic       oneshot;
    logic       sat;
    logic       ovf_clr;
    logic [8:0] count;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 running, 2 finished
    int m_st;
    int m_cnt;
    bit m_done;
    bit m_wrap;
    bit m_ovf;

    incr9_counter #(.RST_VAL(9'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .term     (term),
        .oneshot  (oneshot),
        .sat      (sat),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        start = 0; stop = 0; en = 0; load = 0;
        ovf_clr = 0; load_val = '0;
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_done = 0; m_wrap = 0; m_ovf = 0;
    endtask

    task automatic model_tick();
        int nx;
        m_done = 0;
        m_wrap = 0;
        if (ovf_clr) m_ovf = 0;
        if (stop) begin
            m_st = 0;
            m_cnt = 0;
        end else if (load) begin
            m_cnt = int'(load_val);
            if (m_st == 2 && start) m_st = 1;
        end else if (m_st != 1) begin
            if (start) m_st = 1;
        end else if (en) begin
            nx = m_cnt + 1;
            if (nx > 511) begin
                m_ovf = 1;
                if (sat) nx = 511;
                else begin
                    nx = 0;
                    m_wrap = 1;
                end
            end
            m_cnt = nx;
            if (nx == int'(term)) begin
                m_done = 1;
                if (oneshot) m_st = 2;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, count, 9'(m_cnt));
        chk({tag, ".busy"}, {8'd0, busy}, {8'd0, m_st == 1});
        chk({tag, ".done"}, {8'd0, done}, {8'd0, m_done});
        chk({tag, ".wrap"}, {8'd0, wrap}, {8'd0, m_wrap});
        chk({tag, ".ovf"}, {8'd0, ovf}, {8'd0, m_ovf});
    endtask

    task automatic cyc(input string tag);
        model_tick();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        clr_in();
        term = 9'h100;
        oneshot = 0;
        sat = 0;
        rst_n = 0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1;

        // one-shot to term 5; en alongside start must not count
        start = 1; en = 1;
        cyc("os_start");
        chk("os_start_cnt", count, 9'd0);
        start = 0; oneshot = 1; term = 9'd5;
        for (int i = 1; i <= 5; i++) cyc("os_run");
        chk("os_cnt5", count, 9'd5);
        chk("os_done", {8'd0, done}, 9'd1);
        chk("os_busy", {8'd0, busy}, 9'd0);
        cyc("os_hold");
        chk("os_hold_cnt", count, 9'd5);
        en = 0;

        // continuous wrap from 1FE
        oneshot = 0; term = 9'h100; sat = 0;
        load = 1; load_val = 9'h1FE;
        cyc("wr_load");
        clr_in();
        start = 1;
        cyc("wr_start");
        start = 0; en = 1;
        cyc("wr_1ff");
        cyc("wr_000");
        chk("wr_pulse", {8'd0, wrap}, 9'd1);
        chk("wr_zero", count, 9'd0);
        cyc("wr_001");
        chk("wr_sticky", {8'd0, ovf}, 9'd1);
        en = 0; ovf_clr = 1;
        cyc("wr_clr");
        chk("wr_cleared", {8'd0, ovf}, 9'd0);
        ovf_clr = 0;

        // saturate from 1FE
        sat = 1; load = 1; load_val = 9'h1FE;
        cyc("sat_load");
        load = 0; en = 1;
        for (int i = 0; i < 3; i++) cyc("sat_run");
        chk("sat_cnt", count, 9'h1FF);
        ovf_clr = 1;
        cyc("sat_setwins");
        chk("sat_ovf", {8'd0, ovf}, 9'd1);
        ovf_clr = 0;

        // stop beats load and en; load beats en
        stop = 1; load = 1; load_val = 9'h0AA;
        cyc("pri_stop");
        chk("pri_stop_cnt", count, 9'd0);
        clr_in(); sat = 0;
        start = 1;
        cyc("pri_start");
        start = 0; load = 1; en = 1; load_val = 9'h0AA;
        cyc("pri_load");
        chk("pri_load_cnt", count, 9'h0AA);

        // carry-chain group selects
        load_val = 9'h007; cyc("cc_ld7");
        load = 0; cyc("cc_008");
        chk("cc_008v", count, 9'h008);
        load = 1; load_val = 9'h03F; cyc("cc_ld3f");
        load = 0; cyc("cc_040");
        chk("cc_040v", count, 9'h040);
        load = 1; load_val = 9'h0FF; cyc("cc_ldff");
        load = 0; cyc("cc_100");
        chk("cc_100v", count, 9'h100);

        // async reset mid-RUN with count 055
        load = 1; load_val = 9'h055; en = 0;
        cyc("rs_ld55");
        clr_in();
        #3;
        rst_n = 0;
        model_reset();
        #1;
        chk("rs_cnt", count, 9'd0);
        chk("rs_busy", {8'd0, busy}, 9'd0);
        chk("rs_ovf", {8'd0, ovf}, 9'd0);
        @(negedge clk);
        rst_n = 1;
        en = 1;
        for (int i = 0; i < 3; i++) cyc("rs_idle_en");
        chk("rs_still0", count, 9'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            stop = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 3) == 0) ?
                       9'(9'h1F8 + $urandom_range(0, 7)) :
                       9'($urandom_range(0, 511));
            start = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                term = ($urandom_range(0, 1) == 0) ?
                       9'(count + 9'($urandom_range(0, 12))) :
                       9'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 31) == 0) sat = ~sat;
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
